time_setter: RTL
================

TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter HOLD_COUNT, default 50_000_000: clock cycles a held up/down button must stay high before auto-repeat begins.
REQ-002 Parameter REPEAT_COUNT, default 10_000_000: clock cycles between auto-repeat steps.
REQ-003 Parameter LIMITEMIN, default 7'd99: maximum minutes value.
REQ-004 Parameter LIMITESEC, default 7'd59: maximum seconds value.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, on these ports:
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- up  in  1  increment button, level, already debounced
- down  in  1  decrement button, level, already debounced
- sel  in  1  field-select button, level
- clear  in  1  clear button, level
- lock  in  1  high while the timer is counting or paused; freezes entry
- min  out  7  programmed minutes, 0..LIMITEMIN, feeds the timer min input
- sec  out  7  programmed seconds, 0..LIMITESEC, feeds the timer sec input
- field  out  1  0 = seconds selected, 1 = minutes selected
- valid  out  1  high when min != 0 or sec != 0

Function
REQ-006 Each of up/down/sel/clear SHALL have a registered previous-sample flop; a rising event is current high AND previous low.
REQ-007 An event sampled at rising edge N SHALL take effect on min/sec/field at that same edge N (one-cycle latency from input assertion).
REQ-008 Priority SHALL be clear > sel > up/down; a lower-priority event coincident with a higher one is discarded, with no deferred step.
REQ-009 clear event: min=0, sec=0, field=0, FSM to IDLE, repeat counter=0.
REQ-010 sel event: field toggles; min/sec unchanged.
REQ-011 Step up: selected field +1; LIMITESEC+1 wraps to 0 for seconds, LIMITEMIN+1 wraps to 0 for minutes; no carry between fields.
REQ-012 Step down: selected field -1; 0 wraps to LIMITESEC (seconds) or LIMITEMIN (minutes); no borrow.
REQ-013 FSM states SHALL be IDLE, HOLD, and REPEAT.
REQ-014 IDLE -> HOLD on an up or down rising event with the other button low; one step applied; counter cleared.
REQ-015 HOLD: counter increments each cycle while the originating button stays high; when the counter reaches HOLD_COUNT-1, one step is applied, counter cleared, -> REPEAT.
REQ-016 REPEAT: one step every REPEAT_COUNT cycles while the button stays high.
REQ-017 In HOLD or REPEAT, the originating button going low, or the other direction going high, SHALL return the FSM to IDLE and clear the counter, with no step.
REQ-018 up and down rising together, or one rising while the other is high, SHALL produce no step and leave the FSM in IDLE.
REQ-019 While lock=1, all button events are ignored, the FSM is forced to IDLE, the counter is cleared, and min/sec/field hold their values; previous-sample flops keep updating, so a button held across the lock falling edge does not generate an event.
REQ-020 valid SHALL be combinational from the min/sec registers and reflect any change in the same cycle.
REQ-021 The counter SHALL be wide enough for max(HOLD_COUNT, REPEAT_COUNT) and SHALL never wrap.

Reset
REQ-022 reset=1 SHALL asynchronously force min=0, sec=0, field=0, valid=0, FSM=IDLE, counter=0, and all previous-sample flops=0.
REQ-023 Reset asserted mid-HOLD or mid-REPEAT SHALL abort with no further step; after release, a button still high generates a new rising event on the first clock.
REQ-024 No output SHALL change on the clock edge at which reset is released other than through REQ-023.

Verification (HOLD_COUNT=8, REPEAT_COUNT=4)
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then pulse up 1 cycle -> sec=1, min=0, valid=1 after that edge; field=0.
- sel pulse, then up pulse x3 -> field=1, min=3, sec=0; then down x4 -> min=99.
- sec=59 and field=0, up pulse -> sec=0, min unchanged; down pulse -> sec=59.
- Hold up 20 cycles from sec=0 -> steps at cycles 1, 9, 13, 17 -> sec=4; release -> IDLE, no further change.
- sec=5, lock=1, pulse up/down/sel/clear -> no change; lock=0 with up still held -> no step.
- up and clear rising same cycle at min=2, sec=7 -> min=0, sec=0, valid=0; reset asserted mid-REPEAT -> all outputs 0 immediately.

Source files
------------

// File: rtl/time_setter.sv
// time_setter: front-panel entry of a minutes/seconds preset for a countdown
// timer. Up/down buttons step the selected field (single step on press, then
// auto-repeat after a long hold), sel toggles the field, clear zeroes the
// preset. lock freezes entry while the timer runs.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   up     in   increment button (debounced level)
//   down   in   decrement button (debounced level)
//   sel    in   field-select button (level)
//   clear  in   clear button (level)
//   lock   in   high while the timer is counting or paused
//   min    out  programmed minutes, 0..LIMITEMIN
//   sec    out  programmed seconds, 0..LIMITESEC
//   field  out  0 = seconds selected, 1 = minutes selected
//   valid  out  high when min or sec is non-zero
module time_setter #(
  parameter int unsigned HOLD_COUNT   = 50_000_000,
  parameter int unsigned REPEAT_COUNT = 10_000_000,
  parameter logic [6:0]  LIMITEMIN    = 7'd99,
  parameter logic [6:0]  LIMITESEC    = 7'd59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       sel,
  input  logic       clear,
  input  logic       lock,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       field,
  output logic       valid
);

  localparam int unsigned CNT_MAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_COUNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;      // 1 = up originated the hold
  logic [6:0]       r_min, w_min_nxt;
  logic [6:0]       r_sec, w_sec_nxt;
  logic             r_field, w_field_nxt;
  logic             r_up_prev, r_down_prev, r_sel_prev, r_clear_prev;

  logic w_up_rise, w_down_rise, w_sel_rise, w_clear_rise;
  logic w_held, w_other;
  logic w_step, w_step_up;

  // Edges are combinational from the live input, so a press sampled at an
  // edge takes effect on the outputs at that same edge.
  assign w_up_rise    = up    & ~r_up_prev;
  assign w_down_rise  = down  & ~r_down_prev;
  assign w_sel_rise   = sel   & ~r_sel_prev;
  assign w_clear_rise = clear & ~r_clear_prev;

  assign w_held  = r_dir ? up   : down;
  assign w_other = r_dir ? down : up;

  function automatic logic [6:0] step_val(input logic [6:0] v,
                                          input logic [6:0] lim,
                                          input logic       inc);
    logic [6:0] r;
    if (inc) r = (v >= lim) ? 7'd0 : v + 7'd1;
    else     r = (v == 7'd0) ? lim : v - 7'd1;
    return r;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_min        <= '0;
      r_sec        <= '0;
      r_field      <= 1'b0;
      r_up_prev    <= 1'b0;
      r_down_prev  <= 1'b0;
      r_sel_prev   <= 1'b0;
      r_clear_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_field      <= w_field_nxt;
      // Previous-sample flops track the buttons even while locked, so a
      // button held across unlock produces no event.
      r_up_prev    <= up;
      r_down_prev  <= down;
      r_sel_prev   <= sel;
      r_clear_prev <= clear;
    end
  end

  // Next-state logic. clear and sel (and lock) abort any hold; a coincident
  // up/down event or pending auto-step is dropped, not deferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    w_step_up   = r_dir;
    if (lock || w_clear_rise || w_sel_rise) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_up_rise && !down) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_dir_nxt   = 1'b1;
            w_step      = 1'b1;
            w_step_up   = 1'b1;
          end else if (w_down_rise && !up) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_dir_nxt   = 1'b0;
            w_step      = 1'b1;
            w_step_up   = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!w_held || w_other) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_cnt_nxt   = '0;
            w_step      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_held || w_other) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == REPEAT_LAST) begin
            w_cnt_nxt = '0;
            w_step    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: field values
  always_comb begin
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_field_nxt = r_field;
    if (!lock) begin
      if (w_clear_rise) begin
        w_min_nxt   = '0;
        w_sec_nxt   = '0;
        w_field_nxt = 1'b0;
      end else if (w_sel_rise) begin
        w_field_nxt = ~r_field;
      end else if (w_step) begin
        if (r_field) w_min_nxt = step_val(r_min, LIMITEMIN, w_step_up);
        else         w_sec_nxt = step_val(r_sec, LIMITESEC, w_step_up);
      end
    end
  end

  assign min   = r_min;
  assign sec   = r_sec;
  assign field = r_field;
  assign valid = (r_min != 7'd0) || (r_sec != 7'd0);

endmodule
